rc_mesh_port_array: RTL and testbench
=====================================

Name: rc_mesh_port_array

Overview:
- Parametrised routing-computation stage for one mesh router.
- Generalises the fixed per-node RC blocks to:
  - any node coordinate and mesh size;
  - NPORTS input channels;
  - wormhole route locking;
  - valid/ready handshaking;
  - optional pressure-based adaptive routing.
- Sits between the input FIFOs and the switch allocator. Each input channel gets one registered RC stage that tags every flit with a one-hot output direction.

Parameters:
- NPORTS, 5: input channels; index 0 N, 1 E, 2 S, 3 W, 4 L.
- DATASIZE, 40: flit width.
- WIDTH, 3: pressure width is WIDTH+1 bits.
- COORDW, 2: bits per X/Y coordinate.
- X_CUR, 0: this node's X coordinate.
- Y_CUR, 0: this node's Y coordinate.
- MESH_X, 4: mesh columns.
- MESH_Y, 4: mesh rows.

Ports:
- rc_clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  NPORTS*DATASIZE  packed flits; port p at [p*DATASIZE +: DATASIZE].
- valid_in  in  NPORTS  flit present.
- ready_out  out  NPORTS  stage can accept.
- pressure_in  in  4*(WIDTH+1)  downstream occupancy of N,E,S,W outputs, in that order. Larger value means more congested.
- data_out  out  NPORTS*DATASIZE  registered flit.
- direction_out  out  NPORTS*5  one-hot output per port: bit0 N, bit1 E, bit2 S, bit3 W, bit4 L.
- valid_out  out  NPORTS  registered flit valid.
- rc_ready  in  NPORTS  downstream accepts.
- rc_err  out  NPORTS  sticky protocol error.

Behaviour:
- Flit format:
  - [DATASIZE-1:DATASIZE-2] is the type: 00 body, 01 head, 10 tail, 11 single.
  - Head/single carry dest X at [DATASIZE-3 -: COORDW] and dest Y immediately below it.
- Reset: all of data_out, direction_out, valid_out and rc_err are 0; all ports return to IDLE. A reset mid-packet discards the lock.
- Handshake per port:
  - ready_out = !valid_out || rc_ready.
  - Transfer in when valid_in && ready_out.
  - Latency is exactly 1 cycle (registered).
  - While valid_out && !rc_ready, data_out and direction_out hold stable.
  - Full throughput: a flit is accepted on the same cycle the held one is taken.
- Coordinates: E is +X, W is -X, S is +Y, N is -Y.
- Per-port FSM, state IDLE or LOCKED:
  - IDLE + head accepted: compute route, store it in route_q, go to LOCKED.
  - IDLE + single accepted: compute route, stay IDLE.
  - IDLE + body/tail accepted: pass through with direction_out = L, set rc_err, stay IDLE.
  - LOCKED + body accepted: use route_q, stay LOCKED.
  - LOCKED + tail accepted: use route_q, go to IDLE.
  - LOCKED + head/single accepted: set rc_err, recompute route, state per the head/single rules.
- Deterministic route (XY): dest X != X_CUR gives E/W; otherwise dest Y != Y_CUR gives S/N; otherwise L.
- Edge rule: a direction leaving the mesh (e.g. W at X_CUR=0) is never produced. A destination outside the mesh routes to L and sets rc_err.
- Flits with no valid lock never alter route_q.
- Each port is independent, and all ports share pressure_in. Simultaneous accepts on every port are legal.

Optional Feature:
- Macro: RC_ADAPTIVE_EN.
- Undefined: XY routing; pressure_in is ignored.
- Defined: west-first minimal adaptive routing.
  - If dest X < X_CUR, route W.
  - Otherwise, if both an X candidate (E) and a Y candidate (N/S) are minimal, choose the one with the strictly lower pressure_in; a tie goes to X.
  - Otherwise use the single minimal direction.
- Pressure is sampled on the head-accept cycle only.

Decomposition:
- Package rc_pkg holds:
  - flit type codes;
  - direction one-hot constants (DIR_N/E/S/W/L);
  - port index constants;
  - field offset functions for the dest X/Y fields.
- Sub-module rc_port: one channel's register, FSM, route function and err flag, instantiated NPORTS times with a generate loop.
- Top level does the bus slicing only.

Test Plan:
- X_CUR=2, Y_CUR=1, single flit to (0,1) on port 0 -> next cycle valid_out[0]=1, direction_out[4:0]=01000 (W), rc_err=0.
- Head to (3,3), body, body, tail on port 1 with rc_ready=1 -> all four flits carry E (00010); the port is IDLE after the tail.
- Hold rc_ready[2]=0 for 3 cycles with valid_in=1 -> ready_out[2]=0; data_out and direction_out are stable; on release, both flits appear in order with no loss.
- RC_ADAPTIVE_EN defined, node (1,1), head to (2,2), E pressure=3, S pressure=1 -> S (00100). With equal pressures 2/2 -> E.
- Body flit on IDLE port 3 -> direction L (10000) and rc_err[3]=1, which remains set until rst_n is asserted.
- Assert rst_n=0 after a head on port 4 -> outputs zero immediately. After release, a body flit is flagged as an error, proving the lock was cleared.

Source files
------------

// File: rtl/rc_mesh_port_array_pkg.sv
// Shared types and constants for the mesh routing-computation stage.
// Flit type codes, one-hot directions, port indices and dest-field offsets.
package rc_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } rc_state_e;

  localparam int NDIR = 5;

  localparam logic [NDIR-1:0] DIR_N = 5'b00001;
  localparam logic [NDIR-1:0] DIR_E = 5'b00010;
  localparam logic [NDIR-1:0] DIR_S = 5'b00100;
  localparam logic [NDIR-1:0] DIR_W = 5'b01000;
  localparam logic [NDIR-1:0] DIR_L = 5'b10000;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  function automatic int dx_lsb(int ds, int cw);
    return ds - 2 - cw;
  endfunction

  function automatic int dy_lsb(int ds, int cw);
    return ds - 2 - 2 * cw;
  endfunction

endpackage

// File: rtl/rc_mesh_port_array_if.sv
// Bus bundle between input FIFOs, the RC stage and the switch allocator.
// master drives flits/pressure/downstream ready; slave is the RC stage.
interface rc_mesh_port_array_if #(
  parameter int NPORTS   = 5,
  parameter int DATASIZE = 40,
  parameter int WIDTH    = 3
);
  logic [NPORTS*DATASIZE-1:0] data_in;
  logic [NPORTS-1:0]          valid_in;
  logic [NPORTS-1:0]          ready_out;
  logic [4*(WIDTH+1)-1:0]     pressure_in;
  logic [NPORTS*DATASIZE-1:0] data_out;
  logic [NPORTS*5-1:0]        direction_out;
  logic [NPORTS-1:0]          valid_out;
  logic [NPORTS-1:0]          rc_ready;
  logic [NPORTS-1:0]          rc_err;

  modport master (
    output data_in, valid_in, pressure_in, rc_ready,
    input  ready_out, data_out, direction_out, valid_out, rc_err
  );

  modport slave (
    input  data_in, valid_in, pressure_in, rc_ready,
    output ready_out, data_out, direction_out, valid_out, rc_err
  );

endinterface

// File: rtl/rc_mesh_port_array_port.sv
// One input channel: output register, wormhole lock FSM, route and error flag.
// RC_ADAPTIVE_EN selects west-first pressure-adaptive routing instead of XY.
module rc_port
  import rc_pkg::*;
#(
  parameter int DATASIZE = 40,
  parameter int WIDTH    = 3,
  parameter int COORDW   = 2,
  parameter int X_CUR    = 0,
  parameter int Y_CUR    = 0,
  parameter int MESH_X   = 4,
  parameter int MESH_Y   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [DATASIZE-1:0]    i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [4*(WIDTH+1)-1:0] i_pressure,
  output logic [DATASIZE-1:0]    o_data,
  output logic [NDIR-1:0]        o_dir,
  output logic                   o_valid,
  input  logic                   i_rc_ready,
  output logic                   o_err
);

  localparam int PW  = WIDTH + 1;
  localparam int DXL = dx_lsb(DATASIZE, COORDW);
  localparam int DYL = dy_lsb(DATASIZE, COORDW);
  localparam logic [COORDW-1:0] XC = COORDW'(X_CUR);
  localparam logic [COORDW-1:0] YC = COORDW'(Y_CUR);

  logic [DATASIZE-1:0] r_data;
  logic [NDIR-1:0]     r_dir;
  logic                r_valid;
  logic                r_err;
  rc_state_e           r_state;
  logic [NDIR-1:0]     r_route;

  flit_type_e          w_type;
  logic [COORDW-1:0]   w_dx;
  logic [COORDW-1:0]   w_dy;
  logic                w_oob;
  logic [NDIR-1:0]     w_yd;
  logic [NDIR-1:0]     w_route;
  logic                w_acc;
  logic                w_lead;
  logic                w_follow;

  assign w_type = flit_type_e'(i_data[DATASIZE-1 -: 2]);
  assign w_dx   = i_data[DXL +: COORDW];
  assign w_dy   = i_data[DYL +: COORDW];

`ifdef RC_ADAPTIVE_EN
  logic [PW-1:0] w_pe;
  logic [PW-1:0] w_py;
  logic          w_unused;

  assign w_pe = i_pressure[PORT_E*PW +: PW];
  assign w_py = (w_dy > YC) ? i_pressure[PORT_S*PW +: PW]
                            : i_pressure[PORT_N*PW +: PW];
  // West is always forced, so its pressure never matters
  assign w_unused = ^i_pressure[PORT_W*PW +: PW];
`else
  logic w_unused;

  assign w_unused = ^i_pressure;
`endif

  always_comb begin
    w_oob   = (32'(w_dx) >= MESH_X) || (32'(w_dy) >= MESH_Y);
    w_yd    = (w_dy > YC) ? DIR_S : DIR_N;
    w_route = DIR_L;
    if (w_oob) w_route = DIR_L;
    else if (w_dx < XC) w_route = DIR_W;
`ifdef RC_ADAPTIVE_EN
    else if (w_dx > XC && w_dy != YC)
      w_route = (w_py < w_pe) ? w_yd : DIR_E;
`endif
    else if (w_dx > XC) w_route = DIR_E;
    else if (w_dy != YC) w_route = w_yd;
  end

  assign o_ready  = !r_valid || i_rc_ready;
  assign w_acc    = i_valid && o_ready;
  assign w_lead   = (w_type == FT_HEAD) ||
                    (w_type == FT_SINGLE);
  assign w_follow = (r_state == ST_LOCKED) && !w_lead;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_dir   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_state <= ST_IDLE;
      r_route <= DIR_L;
    end else begin
      if (o_ready) r_valid <= i_valid;
      if (w_acc) begin
        r_data <= i_data;
        unique case (1'b1)
          w_follow: begin
            r_dir <= r_route;
            if (w_type == FT_TAIL) r_state <= ST_IDLE;
          end
          w_lead: begin
            r_dir <= w_route;
            if (w_oob || r_state == ST_LOCKED) r_err <= 1'b1;
            if (w_type == FT_HEAD) begin
              r_route <= w_route;
              r_state <= ST_LOCKED;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          // Body/tail with no lock: deliver locally, flag it
          default: begin
            r_dir <= DIR_L;
            r_err <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_data  = r_data;
  assign o_dir   = r_dir;
  assign o_valid = r_valid;
  assign o_err   = r_err;

endmodule

// File: rtl/rc_mesh_port_array.sv
// Routing-computation stage for one mesh router: NPORTS independent rc_port
// channels sharing pressure_in. Optional macro: RC_ADAPTIVE_EN.
module rc_mesh_port_array
  import rc_pkg::*;
#(
  parameter int NPORTS   = 5,
  parameter int DATASIZE = 40,
  parameter int WIDTH    = 3,
  parameter int COORDW   = 2,
  parameter int X_CUR    = 0,
  parameter int Y_CUR    = 0,
  parameter int MESH_X   = 4,
  parameter int MESH_Y   = 4
) (
  input logic                 rc_clk,
  input logic                 rst_n,
  rc_mesh_port_array_if.slave bus
);

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    rc_port #(
      .DATASIZE (DATASIZE),
      .WIDTH    (WIDTH),
      .COORDW   (COORDW),
      .X_CUR    (X_CUR),
      .Y_CUR    (Y_CUR),
      .MESH_X   (MESH_X),
      .MESH_Y   (MESH_Y)
    ) u_port (
      .i_clk      (rc_clk),
      .i_rst_n    (rst_n),
      .i_data     (bus.data_in[p*DATASIZE +: DATASIZE]),
      .i_valid    (bus.valid_in[p]),
      .o_ready    (bus.ready_out[p]),
      .i_pressure (bus.pressure_in),
      .o_data     (bus.data_out[p*DATASIZE +: DATASIZE]),
      .o_dir      (bus.direction_out[p*NDIR +: NDIR]),
      .o_valid    (bus.valid_out[p]),
      .i_rc_ready (bus.rc_ready[p]),
      .o_err      (bus.rc_err[p])
    );
  end

endmodule

// File: tb/tb_rc_mesh_port_array.sv
// Bench for rc_mesh_port_array at node (2,1) of a 4x4 mesh, 3-bit coords.
// Directed table, corner sequences, then random traffic against a model.
module tb_rc_mesh_port_array;

  localparam int NP = 5;
  localparam int DS = 40;
  localparam int W  = 3;
  localparam int CW = 3;
  localparam int XC = 2;
  localparam int YC = 1;
  localparam int MX = 4;
  localparam int MY = 4;

  localparam logic [4:0] D_N = 5'b00001;
  localparam logic [4:0] D_E = 5'b00010;
  localparam logic [4:0] D_S = 5'b00100;
  localparam logic [4:0] D_W = 5'b01000;
  localparam logic [4:0] D_L = 5'b10000;

  localparam logic [1:0] T_B = 2'b00;
  localparam logic [1:0] T_H = 2'b01;
  localparam logic [1:0] T_T = 2'b10;
  localparam logic [1:0] T_S = 2'b11;

`ifdef RC_ADAPTIVE_EN
  localparam bit ADAPT = 1'b1;
`else
  localparam bit ADAPT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rc_mesh_port_array_if #(.NPORTS(NP), .DATASIZE(DS), .WIDTH(W)) bus ();

  rc_mesh_port_array #(
    .NPORTS(NP), .DATASIZE(DS), .WIDTH(W), .COORDW(CW),
    .X_CUR(XC), .Y_CUR(YC), .MESH_X(MX), .MESH_Y(MY)
  ) dut (
    .rc_clk (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int          port;
    logic [1:0]  typ;
    int          dx;
    int          dy;
    logic [15:0] pr;
    logic [4:0]  dir;
    logic        err;
  } vec_t;

  vec_t tv[23];

  // model state for the random phase
  bit          m_full[NP];
  logic [DS-1:0] m_data[NP];
  logic [4:0]  m_dir[NP];
  bit          m_lock[NP];
  logic [4:0]  m_route[NP];
  bit          m_err[NP];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DS-1:0] mk(input logic [1:0] t, input int dx,
                                       input int dy, input logic [31:0] pl);
    logic [DS-1:0] d;
    d = {t, 3'(dx), 3'(dy), pl};
    return d;
  endfunction

  function automatic vec_t mv(input int p, input logic [1:0] t, input int dx,
                              input int dy, input logic [15:0] pr,
                              input logic [4:0] dir, input logic err);
    vec_t v;
    v.port = p; v.typ = t; v.dx = dx; v.dy = dy;
    v.pr = pr; v.dir = dir; v.err = err;
    return v;
  endfunction

  // spec-level route: out-of-mesh -> L, west first, then X/Y choice
  function automatic logic [4:0] mroute(input int dx, input int dy,
                                        input logic [15:0] pr);
    int pn, pe, ps;
    pn = int'(pr[3:0]);
    pe = int'(pr[7:4]);
    ps = int'(pr[11:8]);
    if (dx >= MX || dy >= MY) return D_L;
    if (dx < XC) return D_W;
    if (ADAPT && dx > XC && dy != YC) begin
      if (dy > YC) return (ps < pe) ? D_S : D_E;
      return (pn < pe) ? D_N : D_E;
    end
    if (dx > XC) return D_E;
    if (dy > YC) return D_S;
    if (dy < YC) return D_N;
    return D_L;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.valid_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [DS-1:0] fa, fb, d;
    logic [1:0]    t;
    logic [4:0]    dir;
    int            p, dx, dy;
    bit            rdy;

    bus.data_in     = '0;
    bus.valid_in    = '0;
    bus.pressure_in = '0;
    bus.rc_ready    = '0;

    #3;
    chk("reset_valid", 64'(bus.valid_out), 0);
    chk("reset_dir", 64'(bus.direction_out), 0);
    chk("reset_err", 64'(bus.rc_err), 0);
    chk("reset_ready", 64'(bus.ready_out), 64'h1f);
    chk("reset_data", 64'(|bus.data_out), 0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rc_ready = '1;

    tv[0]  = mv(0, T_S, 0, 1, 16'h0000, D_W, 0);
    tv[1]  = mv(0, T_S, 2, 1, 16'h0000, D_L, 0);
    tv[2]  = mv(0, T_S, 2, 0, 16'h0000, D_N, 0);
    tv[3]  = mv(0, T_S, 2, 3, 16'h0000, D_S, 0);
    tv[4]  = mv(0, T_S, 3, 1, 16'h0000, D_E, 0);
    tv[5]  = mv(0, T_S, 0, 3, 16'h0000, D_W, 0);
    tv[6]  = mv(0, T_S, 3, 3, 16'h0130, ADAPT ? D_S : D_E, 0);
    tv[7]  = mv(0, T_S, 3, 3, 16'h0220, D_E, 0);
    tv[8]  = mv(0, T_S, 3, 0, 16'h0031, ADAPT ? D_N : D_E, 0);
    tv[9]  = mv(0, T_S, 1, 0, 16'h0f0f, D_W, 0);
    tv[10] = mv(1, T_H, 3, 3, 16'h0000, D_E, 0);
    tv[11] = mv(1, T_B, 0, 0, 16'h0000, D_E, 0);
    tv[12] = mv(1, T_B, 0, 0, 16'h0f00, D_E, 0);
    tv[13] = mv(1, T_T, 0, 0, 16'h0000, D_E, 0);
    tv[14] = mv(1, T_B, 0, 0, 16'h0000, D_L, 1);
    tv[15] = mv(2, T_S, 5, 1, 16'h0000, D_L, 1);
    tv[16] = mv(3, T_B, 0, 0, 16'h0000, D_L, 1);
    tv[17] = mv(4, T_H, 1, 2, 16'h0000, D_W, 0);
    tv[18] = mv(4, T_B, 3, 3, 16'h0000, D_W, 0);
    tv[19] = mv(4, T_H, 2, 3, 16'h0000, D_S, 1);
    tv[20] = mv(4, T_B, 0, 0, 16'h0000, D_S, 1);
    tv[21] = mv(4, T_T, 0, 0, 16'h0000, D_S, 1);
    tv[22] = mv(0, T_S, 0, 0, 16'h0000, D_W, 0);

    for (int i = 0; i < 23; i++) begin
      p = tv[i].port;
      d = mk(tv[i].typ, tv[i].dx, tv[i].dy, 32'(i) ^ 32'hA5A5_0000);
      bus.valid_in = '0;
      bus.valid_in[p] = 1'b1;
      bus.data_in[p*DS +: DS] = d;
      bus.pressure_in = tv[i].pr;
      @(posedge clk);
      #1 bus.valid_in = '0;
      chk($sformatf("tv%0d_valid", i), 64'(bus.valid_out[p]), 1);
      chk($sformatf("tv%0d_dir", i), 64'(bus.direction_out[p*5 +: 5]),
          64'(tv[i].dir));
      chk($sformatf("tv%0d_err", i), 64'(bus.rc_err[p]), 64'(tv[i].err));
      chk($sformatf("tv%0d_data", i), 64'(bus.data_out[p*DS +: DS]), 64'(d));
    end

    // back-pressure on port 2: held flit stable, next one follows
    @(posedge clk);
    #1;
    fa = mk(T_S, 3, 1, 32'h1111_2222);
    fb = mk(T_S, 2, 0, 32'h3333_4444);
    bus.rc_ready[2] = 1'b0;
    bus.valid_in[2] = 1'b1;
    bus.data_in[2*DS +: DS] = fa;
    @(posedge clk);
    #1 bus.data_in[2*DS +: DS] = fb;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("stall%0d_ready", k), 64'(bus.ready_out[2]), 0);
      chk($sformatf("stall%0d_data", k), 64'(bus.data_out[2*DS +: DS]),
          64'(fa));
      chk($sformatf("stall%0d_dir", k), 64'(bus.direction_out[10 +: 5]),
          64'(D_E));
    end
    bus.rc_ready[2] = 1'b1;
    #1 chk("release_ready", 64'(bus.ready_out[2]), 1);
    @(posedge clk);
    #1 bus.valid_in[2] = 1'b0;
    chk("second_valid", 64'(bus.valid_out[2]), 1);
    chk("second_data", 64'(bus.data_out[2*DS +: DS]), 64'(fb));
    chk("second_dir", 64'(bus.direction_out[10 +: 5]), 64'(D_N));
    @(posedge clk);
    #1 chk("drain_valid", 64'(bus.valid_out[2]), 0);

    chk("err3_sticky", 64'(bus.rc_err[3]), 1);

    // reset mid-packet on port 4 drops the lock
    bus.valid_in[4] = 1'b1;
    bus.data_in[4*DS +: DS] = mk(T_H, 3, 1, 32'h0);
    @(posedge clk);
    #1 bus.valid_in[4] = 1'b0;
    chk("p4_head_dir", 64'(bus.direction_out[20 +: 5]), 64'(D_E));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.valid_out), 0);
    chk("arst_dir", 64'(bus.direction_out), 0);
    chk("arst_err", 64'(bus.rc_err), 0);
    chk("arst_data", 64'(|bus.data_out), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.valid_in[4] = 1'b1;
    bus.data_in[4*DS +: DS] = mk(T_B, 0, 0, 32'h5);
    @(posedge clk);
    #1 bus.valid_in[4] = 1'b0;
    chk("postrst_body_dir", 64'(bus.direction_out[20 +: 5]), 64'(D_L));
    chk("postrst_body_err", 64'(bus.rc_err[4]), 1);

    // random traffic against the model
    do_reset();
    for (int q = 0; q < NP; q++) begin
      m_full[q] = 0; m_lock[q] = 0; m_err[q] = 0;
      m_data[q] = '0; m_dir[q] = '0; m_route[q] = D_L;
    end
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      bus.pressure_in = 16'($urandom);
      for (int q = 0; q < NP; q++) begin
        t  = 2'($urandom_range(0, 3));
        dx = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 7)
                                          : $urandom_range(0, 3);
        dy = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 7)
                                          : $urandom_range(0, 3);
        bus.data_in[q*DS +: DS] = mk(t, dx, dy, $urandom);
        bus.valid_in[q] = ($urandom_range(0, 9) < 7);
        bus.rc_ready[q] = ($urandom_range(0, 9) < 7);
      end
      @(negedge clk);
      for (int q = 0; q < NP; q++) begin
        rdy = !m_full[q] || bus.rc_ready[q];
        chk($sformatf("r%0d_p%0d_ready", c, q), 64'(bus.ready_out[q]),
            64'(rdy));
        chk($sformatf("r%0d_p%0d_err", c, q), 64'(bus.rc_err[q]),
            64'(m_err[q]));
        chk($sformatf("r%0d_p%0d_valid", c, q), 64'(bus.valid_out[q]),
            64'(m_full[q]));
        if (m_full[q]) begin
          chk($sformatf("r%0d_p%0d_data", c, q),
              64'(bus.data_out[q*DS +: DS]), 64'(m_data[q]));
          chk($sformatf("r%0d_p%0d_dir", c, q),
              64'(bus.direction_out[q*5 +: 5]), 64'(m_dir[q]));
        end
        if (bus.rc_ready[q]) m_full[q] = 0;
        if (bus.valid_in[q] && rdy) begin
          d  = bus.data_in[q*DS +: DS];
          t  = d[DS-1 -: 2];
          dx = int'(d[DS-3 -: 3]);
          dy = int'(d[DS-6 -: 3]);
          if (t == T_H || t == T_S) begin
            dir = mroute(dx, dy, bus.pressure_in);
            if (dx >= MX || dy >= MY || m_lock[q]) m_err[q] = 1;
            m_lock[q] = (t == T_H);
            if (t == T_H) m_route[q] = dir;
          end else if (m_lock[q]) begin
            dir = m_route[q];
            if (t == T_T) m_lock[q] = 0;
          end else begin
            dir = D_L;
            m_err[q] = 1;
          end
          m_full[q] = 1;
          m_data[q] = d;
          m_dir[q]  = dir;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
